// File: rtl/sd_dev_cmd_rx.sv
// sd_dev_cmd_rx: SD device CMD-line receiver.
// The block samples the CMD line on SD-clock rising-edge strobes. It frames
// 48-bit host commands (start, transmission, index[6], arg[32], CRC7, end),
// checks the CRC7, and presents index and argument through a valid/ack
// handshake.
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   i_en              receiver enable (low aborts any partial frame)
//   i_sd_stb          one-clk SD-clock rising-edge strobe (sampling point)
//   i_sd_cmd_in       CMD line level from the PHY platform stage
//   i_cmd_dir         device is driving CMD; receiver held idle
//   o_busy            frame reception in progress
//   o_cmd_valid       captured command held until i_cmd_ack
//   o_cmd_index/arg   captured command fields
//   o_crc_ok          CRC7 matched and end bit was 1
//   o_frame_err       end bit sampled as 0
//   o_overrun         sticky: frame completed while previous one unacked
//   i_overrun_clr     clears o_overrun (a same-cycle set wins)
module sd_dev_cmd_rx #(
    parameter int FRAME_BITS = 48,
    parameter int CRC_BITS   = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_en,
    input  logic        i_sd_stb,
    input  logic        i_sd_cmd_in,
    input  logic        i_cmd_dir,
    output logic        o_busy,
    output logic        o_cmd_valid,
    input  logic        i_cmd_ack,
    output logic [5:0]  o_cmd_index,
    output logic [31:0] o_cmd_arg,
    output logic        o_crc_ok,
    output logic        o_frame_err,
    output logic        o_overrun,
    input  logic        i_overrun_clr
);
    localparam logic [5:0] LAST_BIT = 6'(FRAME_BITS - 1);
    localparam logic [5:0] CRC_END  = 6'(FRAME_BITS - CRC_BITS - 2); // last CRC-covered bit

    typedef enum logic {IDLE, RX} state_t;

    state_t        state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [6:0]    crc_q, crc_d;
    logic [6:0]    rxcrc_q, rxcrc_d;
    logic [5:0]    idx_q, idx_d;
    logic [31:0]   arg_q, arg_d;
    logic          valid_q, valid_d;
    logic [5:0]    oidx_q, oidx_d;
    logic [31:0]   oarg_q, oarg_d;
    logic          ok_q, ok_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          done;
    logic          ovr_set;

    // Serial CRC7 step, x^7+x^3+1, MSB first.
    function automatic logic [6:0] crc_step(input logic [6:0] c, input logic b);
        logic fb;
        fb = b ^ c[6];
        return {c[5:3], c[2] ^ fb, c[1:0], fb};
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        rxcrc_d = rxcrc_q;
        idx_d   = idx_q;
        arg_d   = arg_q;
        valid_d = valid_q;
        oidx_d  = oidx_q;
        oarg_d  = oarg_q;
        ok_d    = ok_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        done    = 1'b0;
        ovr_set = 1'b0;

        if (!i_en || i_cmd_dir) begin
            // Abort takes priority over sampling; the held output is untouched.
            state_d = IDLE;
            cnt_d   = '0;
        end else if (i_sd_stb) begin
            unique case (state_q)
                IDLE: begin
                    if (!i_sd_cmd_in) begin
                        state_d = RX;
                        cnt_d   = 6'd1;
                        crc_d   = crc_step(7'd0, 1'b0);
                    end
                end
                RX: begin
                    if (cnt_q == 6'd1 && !i_sd_cmd_in) begin
                        // Transmission bit 0: another card's response, drop silently.
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        if (cnt_q <= CRC_END)
                            crc_d = crc_step(crc_q, i_sd_cmd_in);
                        if (cnt_q >= 6'd2 && cnt_q <= 6'd7)
                            idx_d = {idx_q[4:0], i_sd_cmd_in};
                        if (cnt_q >= 6'd8 && cnt_q <= CRC_END)
                            arg_d = {arg_q[30:0], i_sd_cmd_in};
                        if (cnt_q > CRC_END && cnt_q < LAST_BIT)
                            rxcrc_d = {rxcrc_q[5:0], i_sd_cmd_in};
                        if (cnt_q == LAST_BIT) begin
                            done    = 1'b1;
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 6'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // A new frame may load when the slot is free or is being acked right now.
        if (done) begin
            if (!valid_q || i_cmd_ack) begin
                valid_d = 1'b1;
                oidx_d  = idx_q;
                oarg_d  = arg_q;
                ok_d    = (rxcrc_q == crc_q) && i_sd_cmd_in;
                ferr_d  = !i_sd_cmd_in;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (i_cmd_ack) begin
            valid_d = 1'b0;
        end

        if (ovr_set)
            ovr_d = 1'b1;
        else if (i_overrun_clr)
            ovr_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            crc_q   <= '0;
            rxcrc_q <= '0;
            idx_q   <= '0;
            arg_q   <= '0;
            valid_q <= 1'b0;
            oidx_q  <= '0;
            oarg_q  <= '0;
            ok_q    <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            rxcrc_q <= rxcrc_d;
            idx_q   <= idx_d;
            arg_q   <= arg_d;
            valid_q <= valid_d;
            oidx_q  <= oidx_d;
            oarg_q  <= oarg_d;
            ok_q    <= ok_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_busy      = (state_q == RX);
    assign o_cmd_valid = valid_q;
    assign o_cmd_index = oidx_q;
    assign o_cmd_arg   = oarg_q;
    assign o_crc_ok    = ok_q;
    assign o_frame_err = ferr_q;
    assign o_overrun   = ovr_q;
endmodule

// File: tb/tb_sd_dev_cmd_rx.sv
// Bench for sd_dev_cmd_rx: directed frames plus randomized traffic. Each cycle
// the outputs are compared with a frame-level model.
module tb_sd_dev_cmd_rx;
    logic        clk = 1'b0, rst = 1'b1, en = 1'b0, stb = 1'b0, cmd = 1'b1;
    logic        dir = 1'b0, ack = 1'b0, oclr = 1'b0;
    logic        o_busy, o_cmd_valid, o_crc_ok, o_frame_err, o_overrun;
    logic [5:0]  o_cmd_index;
    logic [31:0] o_cmd_arg;

    int checks = 0, errors = 0;
    bit armed = 1'b0, rmode = 1'b0;

    sd_dev_cmd_rx #(.FRAME_BITS(48), .CRC_BITS(7)) dut (
        .clk(clk), .rst(rst), .i_en(en), .i_sd_stb(stb), .i_sd_cmd_in(cmd),
        .i_cmd_dir(dir), .o_busy(o_busy), .o_cmd_valid(o_cmd_valid),
        .i_cmd_ack(ack), .o_cmd_index(o_cmd_index), .o_cmd_arg(o_cmd_arg),
        .o_crc_ok(o_crc_ok), .o_frame_err(o_frame_err), .o_overrun(o_overrun),
        .i_overrun_clr(oclr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // CRC7 as polynomial long division of msg * x^7 by x^7+x^3+1.
    function automatic logic [6:0] crc7(input logic [39:0] msg);
        logic [46:0] r;
        r = {msg, 7'b0};
        for (int i = 46; i >= 7; i--)
            if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
        return r[6:0];
    endfunction

    // Frame-level model: collect bits into a 48-bit frame, interpret on completion.
    logic        m_in = 1'b0, m_valid = 1'b0, m_ok = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;
    int          m_n = 0;
    logic [47:0] m_fb = '0;
    logic [5:0]  m_idx = '0;
    logic [31:0] m_arg = '0;
    logic        m_done, m_set;

    always @(posedge clk) begin
        if (rst) begin
            m_in = 0; m_n = 0; m_valid = 0; m_idx = 0; m_arg = 0;
            m_ok = 0; m_ferr = 0; m_ovr = 0;
        end else begin
            m_done = 0; m_set = 0;
            if (!en || dir) m_in = 0;
            else if (stb) begin
                if (!m_in) begin
                    if (!cmd) begin m_in = 1; m_fb[47] = 1'b0; m_n = 1; end
                end else begin
                    m_fb[47 - m_n] = cmd;
                    if (m_n == 1 && !cmd) m_in = 0;
                    else if (m_n == 47) begin m_in = 0; m_done = 1; end
                    else m_n++;
                end
            end
            if (m_done) begin
                if (!m_valid || ack) begin
                    m_valid = 1;
                    m_idx   = m_fb[45:40];
                    m_arg   = m_fb[39:8];
                    m_ok    = (crc7(m_fb[47:8]) == m_fb[7:1]) && m_fb[0];
                    m_ferr  = !m_fb[0];
                end else m_set = 1;
            end else if (ack) m_valid = 0;
            if (m_set) m_ovr = 1;
            else if (oclr) m_ovr = 0;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("busy",     32'(o_busy),      32'(m_in));
            chk("valid",    32'(o_cmd_valid), 32'(m_valid));
            chk("overrun",  32'(o_overrun),   32'(m_ovr));
            chk("index",    32'(o_cmd_index), 32'(m_idx));
            chk("arg",      o_cmd_arg,        m_arg);
            chk("crc_ok",   32'(o_crc_ok),    32'(m_ok));
            chk("frame_err",32'(o_frame_err), 32'(m_ferr));
        end
    end

    task automatic gap_cycles();
        int g;
        g = $urandom_range(0, 3);
        repeat (g) begin
            @(negedge clk);
            stb = 1'b0;
            cmd = 1'($urandom_range(0, 1));   // glitches between strobes
            if (rmode) begin
                ack  = ($urandom_range(0, 3) == 0);
                oclr = ($urandom_range(0, 7) == 0);
                dir  = ($urandom_range(0, 199) == 0);
            end
        end
    endtask

    // Send the top nb bits of f, one per strobe; optional ack in the last strobe clk.
    task automatic send_bits(input logic [47:0] f, input int nb, input logic ack_last);
        for (int i = 0; i < nb; i++) begin
            gap_cycles();
            @(negedge clk);
            stb = 1'b1;
            cmd = f[47 - i];
            if (ack_last && i == nb - 1) ack = 1'b1;
        end
        @(negedge clk);
        stb = 1'b0; cmd = 1'b1; ack = 1'b0; oclr = 1'b0; dir = 1'b0;
    endtask

    task automatic do_ack();
        @(negedge clk) ack = 1'b1;
        @(negedge clk) ack = 1'b0;
    endtask

    localparam logic [47:0] CMD0  = 48'h40_00000000_95;
    localparam logic [47:0] CMD8  = 48'h48_000001AA_87;
    localparam logic [47:0] CMD8B = 48'h48_000001AA_85;
    localparam logic [47:0] CMD0E = 48'h40_00000000_94;
    localparam logic [47:0] TX0   = 48'h00_00000000_00;

    initial begin
        logic [5:0]  ri;
        logic [31:0] ra;
        logic [47:0] rf;
        int          nb;

        repeat (2) @(negedge clk);
        armed = 1'b1;
        chk("reset valid",   32'(o_cmd_valid), 32'd0);
        chk("reset busy",    32'(o_busy),      32'd0);
        chk("reset overrun", 32'(o_overrun),   32'd0);
        chk("reset crc_ok",  32'(o_crc_ok),    32'd0);
        @(negedge clk) rst = 1'b0; en = 1'b1;
        repeat (3) @(negedge clk);

        // CMD0
        send_bits(CMD0, 48, 1'b0);
        chk("cmd0 valid",  32'(o_cmd_valid), 32'd1);
        chk("cmd0 index",  32'(o_cmd_index), 32'd0);
        chk("cmd0 arg",    o_cmd_arg,        32'h0);
        chk("cmd0 crc_ok", 32'(o_crc_ok),    32'd1);
        chk("cmd0 ferr",   32'(o_frame_err), 32'd0);
        do_ack();
        chk("ack clears valid", 32'(o_cmd_valid), 32'd0);

        // CMD8 good and bad CRC
        send_bits(CMD8, 48, 1'b0);
        chk("cmd8 index",  32'(o_cmd_index), 32'd8);
        chk("cmd8 arg",    o_cmd_arg,        32'h1AA);
        chk("cmd8 crc_ok", 32'(o_crc_ok),    32'd1);
        do_ack();
        send_bits(CMD8B, 48, 1'b0);
        chk("bad crc valid",  32'(o_cmd_valid), 32'd1);
        chk("bad crc crc_ok", 32'(o_crc_ok),    32'd0);
        chk("bad crc ferr",   32'(o_frame_err), 32'd0);
        do_ack();

        // End bit 0
        send_bits(CMD0E, 48, 1'b0);
        chk("endbit valid",  32'(o_cmd_valid), 32'd1);
        chk("endbit ferr",   32'(o_frame_err), 32'd1);
        chk("endbit crc_ok", 32'(o_crc_ok),    32'd0);
        do_ack();

        // Transmission bit 0: silent abort, then normal CMD0
        send_bits(TX0, 2, 1'b0);
        chk("tx0 busy",  32'(o_busy),      32'd0);
        chk("tx0 valid", 32'(o_cmd_valid), 32'd0);
        send_bits(CMD0, 48, 1'b0);
        chk("after tx0 crc_ok", 32'(o_crc_ok), 32'd1);
        do_ack();

        // Overrun, clear, then ack coinciding with completion
        send_bits(CMD8, 48, 1'b0);
        send_bits(CMD0, 48, 1'b0);
        chk("ovr set",   32'(o_overrun),   32'd1);
        chk("ovr index", 32'(o_cmd_index), 32'd8);
        @(negedge clk) oclr = 1'b1;
        @(negedge clk) oclr = 1'b0;
        chk("ovr clr", 32'(o_overrun), 32'd0);
        do_ack();
        send_bits(CMD8, 48, 1'b0);
        send_bits(CMD0, 48, 1'b1);
        chk("ack+done index", 32'(o_cmd_index), 32'd0);
        chk("ack+done valid", 32'(o_cmd_valid), 32'd1);
        chk("ack+done ovr",   32'(o_overrun),   32'd0);
        do_ack();

        // Enable drop at bit 20
        send_bits(CMD8, 21, 1'b0);
        chk("mid busy", 32'(o_busy), 32'd1);
        @(negedge clk) en = 1'b0;
        @(negedge clk) en = 1'b1;
        chk("en drop busy",  32'(o_busy),      32'd0);
        chk("en drop valid", 32'(o_cmd_valid), 32'd0);
        send_bits(CMD0, 48, 1'b0);
        chk("re-en valid",  32'(o_cmd_valid), 32'd1);
        chk("re-en crc_ok", 32'(o_crc_ok),    32'd1);
        send_bits(CMD8, 48, 1'b0);   // overrun with CMD0 held

        // Reset mid-frame
        send_bits(CMD8, 20, 1'b0);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        chk("rst valid",   32'(o_cmd_valid), 32'd0);
        chk("rst busy",    32'(o_busy),      32'd0);
        chk("rst overrun", 32'(o_overrun),   32'd0);
        chk("rst crc_ok",  32'(o_crc_ok),    32'd0);

        // Randomized traffic
        rmode = 1'b1;
        for (int k = 0; k < 40; k++) begin
            ri = 6'($urandom);
            ra = $urandom;
            rf = {2'b01, ri, ra, crc7({2'b01, ri, ra}), 1'b1};
            if ($urandom_range(0, 3) == 0) rf[7:1] = rf[7:1] ^ 7'($urandom_range(1, 127));
            if ($urandom_range(0, 7) == 0) rf[0] = 1'b0;
            if ($urandom_range(0, 7) == 0) rf[46] = 1'b0;
            nb = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 47) : 48;
            send_bits(rf, nb, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 9) == 0) begin
                @(negedge clk) en = 1'b0;
                @(negedge clk) en = 1'b1;
            end
        end
        rmode = 1'b0;
        repeat (4) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sd_dev_cmd_rx.md
Name: sd_dev_cmd_rx

Overview:
- Command-line receiver for the SD device stack. Sits directly downstream of the device PHY platform stage and consumes its raw CMD-line input (o_sd_cmd_in).
- Samples the CMD line on SD-clock rising-edge strobes and frames 48-bit host commands (start, transmission, index, argument, CRC7, end).
- Checks CRC7 and presents index/argument to the command decoder through a valid/ack handshake.

Parameters:
- FRAME_BITS, 48, total command frame length in bits, including start and end bits.
- CRC_BITS, 7, CRC width; polynomial x^7+x^3+1, initial value 0.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- i_en  input  1  receiver enable; low forces IDLE and discards any partial frame
- i_sd_stb  input  1  one-clk pulse marking the SD-clock rising edge; sampling point
- i_sd_cmd_in  input  1  CMD line level from PHY platform (o_sd_cmd_in)
- i_cmd_dir  input  1  high while the device is driving CMD (response tx); receiver held in IDLE
- o_busy  output  1  high while a frame is being received (state RX)
- o_cmd_valid  output  1  captured command available; held until acknowledged
- i_cmd_ack  input  1  consumer accepts the command; clears o_cmd_valid next clk
- o_cmd_index  output  6  command index
- o_cmd_arg  output  32  command argument
- o_crc_ok  output  1  qualifies o_cmd_valid: CRC7 matched and end bit was 1
- o_frame_err  output  1  qualifies o_cmd_valid: end bit sampled as 0
- o_overrun  output  1  sticky: a frame completed while a previous one was unacknowledged
- i_overrun_clr  input  1  clears o_overrun

Behaviour:
- Reset: all outputs 0; state IDLE; bit counter 0; CRC register 0.
- All sampling happens only in clk cycles where i_sd_stb=1. Other cycles hold the datapath.
- IDLE:
  - On a strobe with i_en=1, i_cmd_dir=0 and i_sd_cmd_in=0 (start bit): go to RX, bit count=1, CRC reset to 0 then updated with the start bit.
  - A 1 on the line keeps the block in IDLE.
- RX, sampling bits 1..47:
  - Bit 1 (transmission bit) must be 1. If it is 0 (another card's response), abort to IDLE silently; no valid, no error.
  - Bits 0..39 feed CRC7 serially, MSB-first:
    - fb = bit ^ crc[6]
    - crc <= {crc[5:3], crc[2]^fb, crc[1:0], fb}
  - Bits 2..7 shift into the index, MSB first. Bits 8..39 shift into the argument, MSB first. Bits 40..46 shift into the received CRC.
  - Bit 47 is the end bit and finishes the frame.
- Completion, on the strobe that samples bit 47:
  - Return to IDLE.
  - One clk later: o_cmd_valid=1; o_cmd_index and o_cmd_arg updated; o_crc_ok = (rx_crc==calc_crc) && end_bit; o_frame_err = !end_bit.
- Handshake:
  - o_cmd_valid stays high, and outputs stay stable, until i_cmd_ack is sampled high; o_cmd_valid falls the next clk.
  - i_cmd_ack while o_cmd_valid=0 is ignored.
- Overrun:
  - If a frame completes while o_cmd_valid=1 and i_cmd_ack=0 in the same clk, the new frame is dropped, the old outputs are kept, and o_overrun is set.
  - If ack and completion coincide, the new frame loads, o_cmd_valid stays 1, and there is no overrun.
  - i_overrun_clr clears o_overrun; if a set event occurs in the same clk, set wins.
- i_en=0 or i_cmd_dir=1 at any time: immediate return to IDLE and the partial frame is discarded. A held o_cmd_valid and its outputs are unaffected.
- o_busy=1 exactly while in RX.
- Back-to-back frames: a start bit on the strobe immediately after the end bit must be accepted. No dead strobe is required.
- A strobe with no frame activity has no effect. Line glitches between strobes are invisible.

Test Plan:
- CMD0 frame 0x40_00000000_95 sent MSB-first, one bit per strobe -> o_cmd_valid=1 one clk after the end-bit strobe; index=0, arg=0x00000000, crc_ok=1, frame_err=0; ack -> valid=0 next clk.
- CMD8 frame 0x48_000001AA_87 -> index=8, arg=0x000001AA, crc_ok=1. Repeat with CRC byte 0x85 -> crc_ok=0, frame_err=0, valid still asserted.
- CMD0 with end bit forced to 0 (last byte 0x94) -> valid=1, frame_err=1, crc_ok=0.
- Frame with transmission bit 0 (first byte 0x00) -> no valid, returns to IDLE (o_busy falls after bit 1). A following correct CMD0 is received normally.
- CMD8 then CMD0 back-to-back with no ack -> second dropped, o_overrun=1, outputs still index 8. Repeat with ack asserted in the completion clk -> index=0, no overrun. i_overrun_clr -> o_overrun=0.
- i_en dropped at bit 20 of CMD8 -> o_busy=0 next clk, no valid. Re-enable and send CMD0 -> correct capture. rst mid-frame -> all outputs 0.
